// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the seven-segment scan driver
//
// Purpose : glyph constants (active-low, bit7 = dp, bits6..0 = g..a), the
//           blank pattern, the scan FSM state type and a dp helper.
// Ports   : none (package).
package seg7_pkg;

  // All segments dark, including the decimal point.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Decimal digits 0-9, dp dark.
  localparam logic [7:0] GLYPH_0 = 8'hC0;
  localparam logic [7:0] GLYPH_1 = 8'hF9;
  localparam logic [7:0] GLYPH_2 = 8'hA4;
  localparam logic [7:0] GLYPH_3 = 8'hB0;
  localparam logic [7:0] GLYPH_4 = 8'h99;
  localparam logic [7:0] GLYPH_5 = 8'h92;
  localparam logic [7:0] GLYPH_6 = 8'h82;
  localparam logic [7:0] GLYPH_7 = 8'hF8;
  localparam logic [7:0] GLYPH_8 = 8'h80;
  localparam logic [7:0] GLYPH_9 = 8'h90;

  // Hex letters A-F, only used when the hex glyph set is built in.
  localparam logic [7:0] GLYPH_A = 8'h88;
  localparam logic [7:0] GLYPH_B = 8'h83;
  localparam logic [7:0] GLYPH_C = 8'hC6;
  localparam logic [7:0] GLYPH_D = 8'hA1;
  localparam logic [7:0] GLYPH_E = 8'h86;
  localparam logic [7:0] GLYPH_F = 8'h8E;

  typedef enum logic {
    ST_OFF  = 1'b0,
    ST_SCAN = 1'b1
  } seg7_state_e;

  // Segments are active-low, so a lit decimal point clears bit7.
  function automatic logic [7:0] seg7_apply_dp(input logic [7:0] glyph, input logic dp);
    return dp ? {1'b0, glyph[6:0]} : glyph;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational nibble to seven-segment glyph decoder
//
// Purpose : maps one 4-bit nibble plus its decimal point to an active-low
//           glyph. Optional macro SEG7_HEX_EN adds letters A-F; without it
//           those nibbles decode to blank (dp still applied).
// Ports   : nibble_i [3:0] - digit value
//           dp_i           - 1 = decimal point lit
//           glyph_o  [7:0] - active-low segments, bit7 = dp, bits6..0 = g..a
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] glyph_o
);

  logic [7:0] base_glyph;

  always_comb begin
    base_glyph = SEG_BLANK;
    case (nibble_i)
      4'h0: base_glyph = GLYPH_0;
      4'h1: base_glyph = GLYPH_1;
      4'h2: base_glyph = GLYPH_2;
      4'h3: base_glyph = GLYPH_3;
      4'h4: base_glyph = GLYPH_4;
      4'h5: base_glyph = GLYPH_5;
      4'h6: base_glyph = GLYPH_6;
      4'h7: base_glyph = GLYPH_7;
      4'h8: base_glyph = GLYPH_8;
      4'h9: base_glyph = GLYPH_9;
`ifdef SEG7_HEX_EN
      4'hA: base_glyph = GLYPH_A;
      4'hB: base_glyph = GLYPH_B;
      4'hC: base_glyph = GLYPH_C;
      4'hD: base_glyph = GLYPH_D;
      4'hE: base_glyph = GLYPH_E;
      4'hF: base_glyph = GLYPH_F;
`else
      default: base_glyph = SEG_BLANK;
`endif
    endcase
  end

  assign glyph_o = seg7_apply_dp(base_glyph, dp_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment display scan driver
//
// Purpose : time-multiplexes N_DIGITS digits onto one shared segment bus.
//           A prescaler produces a tick every REFRESH_DIV clocks; each tick
//           steps to the next digit. New contents are taken through a
//           load/ready handshake and applied only on frame boundaries so a
//           frame never shows a mix of old and new digits.
//           Optional macro SEG7_HEX_EN (in seg7_decode) enables A-F glyphs.
// Ports   : clk              - clock, rising edge
//           rst_n            - asynchronous active-low reset
//           enable           - 1 = scan, 0 = all digits dark
//           load / ready     - content update handshake
//           value [4N-1:0]   - nibbles, nibble 0 is the rightmost digit
//           dp_in [N-1:0]    - decimal point per digit, 1 = lit
//           blank_lz         - 1 = suppress leading zeros (taken live)
//           catodo [7:0]     - active-low segments, bit7 = dp
//           anodo [N-1:0]    - active-low digit select
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  output logic                  ready,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  output logic [7:0]            catodo,
  output logic [N_DIGITS-1:0]   anodo
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  seg7_state_e state_q, state_d;
  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*N_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                  ready_q, ready_d;
  logic [7:0]            catodo_q, catodo_d;
  logic [N_DIGITS-1:0]   anodo_q, anodo_d;

  logic tick;
  logic frame_bd;
  logic accept;
  logic apply;

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------
  assign tick     = (state_q == ST_SCAN) && (presc_q == PRE_LAST);
  assign frame_bd = tick && (idx_q == IDX_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    case (state_q)
      ST_OFF: begin
        if (enable) begin
          // Every scan session starts with a full slot on digit 0.
          state_d = ST_SCAN;
          presc_d = '0;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (!enable) begin
          state_d = ST_OFF;
        end else if (tick) begin
          presc_d = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load handshake. ready low doubles as "pending holds unapplied data", so a
  // load accepted on a boundary edge is only applied at the following one.
  // ---------------------------------------------------------------------------
  assign accept = load && ready_q;
  assign apply  = !ready_q && ((state_q == ST_OFF) || frame_bd);

  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    ready_d    = ready_q;
    if (accept) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
      ready_d    = 1'b0;
    end else if (apply) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      ready_d    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Glyph selection for the current digit
  // ---------------------------------------------------------------------------
  // zero_above[i] = nibble i and every nibble to its left are zero.
  logic [N_DIGITS-1:0] zero_above;

  always_comb begin
    zero_above = '0;
    zero_above[N_DIGITS-1] = (disp_val_q[4*(N_DIGITS-1) +: 4] == 4'h0);
    for (int i = N_DIGITS - 2; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] && (disp_val_q[4*i +: 4] == 4'h0);
    end
  end

  logic [3:0] sel_nib;
  logic       sel_dp;
  logic       sel_blank;
  logic [7:0] dec_glyph;
  logic [7:0] sel_glyph;

  assign sel_nib   = disp_val_q[4*int'(idx_q) +: 4];
  assign sel_dp    = disp_dp_q[idx_q];
  // Digit 0 always shows, so an all-zero value still reads "0".
  assign sel_blank = blank_lz && (idx_q != '0) && zero_above[idx_q];

  seg7_decode u_decode (
    .nibble_i (sel_nib),
    .dp_i     (sel_dp),
    .glyph_o  (dec_glyph)
  );

  assign sel_glyph = sel_blank ? seg7_apply_dp(SEG_BLANK, sel_dp) : dec_glyph;

  // Outputs are registered from the current index, so the display trails the
  // index by one cycle; enable gates them so dropping it darkens at once.
  always_comb begin
    anodo_d  = '1;
    catodo_d = SEG_BLANK;
    if ((state_q == ST_SCAN) && enable) begin
      anodo_d  = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q);
      catodo_d = sel_glyph;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      presc_q    <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      ready_q    <= 1'b1;
      catodo_q   <= SEG_BLANK;
      anodo_q    <= '1;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      ready_q    <= ready_d;
      catodo_q   <= catodo_d;
      anodo_q    <= anodo_d;
    end
  end

  assign ready  = ready_q;
  assign catodo = catodo_q;
  assign anodo  = anodo_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

`ifdef SEG7_HEX_EN
  localparam logic [7:0] GLYPHS [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  localparam logic [7:0] EXP_B_DP = 8'h03;
`else
  localparam logic [7:0] GLYPHS [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  localparam logic [7:0] EXP_B_DP = 8'h7F;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        ready;
  logic [7:0]  catodo;
  logic [3:0]  anodo;

  seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .load     (load),
    .ready    (ready),
    .value    (value),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .catodo   (catodo),
    .anodo    (anodo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: time since entering scan, digit = (t / DIV) mod N,
  // frame boundary every FRAME cycles. Outputs show one cycle later.
  // ---------------------------------------------------------------------------
  bit          m_scan = 0;
  int          m_cnt = 0;
  bit          m_ready = 1;
  logic [15:0] m_disp_v = '0, m_pend_v = '0;
  logic [3:0]  m_disp_dp = '0, m_pend_dp = '0;
  logic [3:0]  m_an = 4'hF;
  logic [7:0]  m_cat = 8'hFF;
  int          m_d;
  bit          m_bd, m_acc, m_app;

  function automatic logic [7:0] glyph_of(input int d, input logic [15:0] v,
                                          input logic [3:0] dp, input bit blz);
    logic [15:0] upper;
    logic [7:0]  g;
    upper = v >> (4 * d);
    if (blz && d != 0 && upper == 16'h0) g = 8'hFF;
    else                                 g = GLYPHS[upper[3:0]];
    if (dp[d]) g[7] = 1'b0;
    return g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scan = 0; m_cnt = 0; m_ready = 1;
      m_disp_v = '0; m_pend_v = '0; m_disp_dp = '0; m_pend_dp = '0;
      m_an = 4'hF; m_cat = 8'hFF;
    end else begin
      m_d = (m_cnt / DIV) % N;
      if (m_scan && enable) begin
        m_an  = ~(4'b0001 << m_d);
        m_cat = glyph_of(m_d, m_disp_v, m_disp_dp, blank_lz);
      end else begin
        m_an  = 4'hF;
        m_cat = 8'hFF;
      end
      m_bd  = m_scan && (m_cnt % FRAME == FRAME - 1);
      m_acc = load && m_ready;
      m_app = !m_ready && (!m_scan || m_bd);
      if (m_app) begin
        m_disp_v = m_pend_v; m_disp_dp = m_pend_dp; m_ready = 1;
      end
      if (m_acc) begin
        m_pend_v = value; m_pend_dp = dp_in; m_ready = 0;
      end
      if (!m_scan) begin
        if (enable) begin m_scan = 1; m_cnt = 0; end
      end else if (!enable) begin
        m_scan = 0;
      end else begin
        m_cnt = (m_cnt + 1) % FRAME;
      end
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_anodo", anodo, m_an);
      chk("model_catodo", catodo, m_cat);
      chk("model_ready", ready, m_ready);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", ready, 1'b1);
  endtask

  // Returns at the first cycle digit 0 of the new contents is shown.
  task automatic load_and_wait(input logic [15:0] v, input logic [3:0] dp);
    wait_ready();
    load = 1'b1; value = v; dp_in = dp;
    @(negedge clk);
    load = 1'b0;
    wait_ready();
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    logic [3:0] an_exp;
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < N; k++) begin
      an_exp = ~(4'b0001 << k);
      chk({tag, "_anodo"}, anodo, an_exp);
      chk({tag, "_catodo"}, catodo, e[k]);
      repeat (DIV) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    @(negedge clk);
    chk("reset_ready", ready, 1'b1);
    chk("reset_anodo", anodo, 4'hF);
    chk("reset_catodo", catodo, 8'hFF);
    cmp_en = 1;
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;

    // Basic scan of 1234.
    load_and_wait(16'h1234, 4'h0);
    check_frame("scan1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Leading-zero suppression, then the same contents with it off (live).
    blank_lz = 1'b1;
    load_and_wait(16'h0040, 4'h0);
    check_frame("lz_on", 8'hC0, 8'h99, 8'hFF, 8'hFF);
    blank_lz = 1'b0;
    check_frame("lz_off", 8'hC0, 8'h99, 8'hC0, 8'hC0);

    // Hex nibble with decimal point.
    load_and_wait(16'h000B, 4'h1);
    check_frame("hex_b_dp", EXP_B_DP, 8'hC0, 8'hC0, 8'hC0);

    // Load exactly on a frame-boundary edge; a second load while busy is dropped.
    n = 0;
    while (!(m_scan && m_cnt == FRAME - 1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("boundary_found", (n < 100), 1'b1);
    load = 1'b1; value = 16'h5678; dp_in = 4'h0;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (ready === 1'b0 && n < 40) begin
      n++;
      if (n == 2) chk("old_held_digit0", catodo, EXP_B_DP);
      if (n == 4) begin load = 1'b1; value = 16'h9999; end
      if (n == 5) load = 1'b0;
      @(negedge clk);
    end
    chk("ready_low_cycles", n, 16);
    @(negedge clk);
    check_frame("after_bd_load", 8'h80, 8'hF8, 8'h82, 8'h92);

    // Drop enable mid-slot, then restart at digit 0 with a full slot.
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_anodo", anodo, 4'hF);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("reenable_dark", anodo, 4'hF);
    @(negedge clk);
    for (int k = 0; k < DIV; k++) begin
      chk("reenable_slot0", anodo, 4'hE);
      @(negedge clk);
    end
    chk("reenable_slot1", anodo, 4'hD);

    // Reset mid-frame with a pending load.
    wait_ready();
    load = 1'b1; value = 16'h4321; dp_in = 4'hF;
    @(negedge clk);
    load = 1'b0;
    chk("pending_ready_low", ready, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_anodo", anodo, 4'hF);
    chk("async_rst_catodo", catodo, 8'hFF);
    chk("async_rst_ready", ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_frame("after_reset", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      load     = ($urandom_range(0, 7) == 0);
      value    = 16'($urandom) >> $urandom_range(0, 16);
      dp_in    = 4'($urandom);
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      if (enable) begin
        if ($urandom_range(0, 199) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        enable = 1'b1;
      end
      @(negedge clk);
    end
    load = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
